// File: rtl/bcd_pkg.sv
// Shared types and sizing for the sequential BCD-to-binary converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    localparam int unsigned NDIGITS = 4;
    localparam int unsigned BINW    = 14;
    localparam int unsigned ITER    = 14;
    localparam int unsigned CNTW    = 4;
    localparam int unsigned BCDW    = NDIGITS * 4;
    localparam int unsigned SRW     = BCDW + BINW;

    // True when every packed digit is a legal decimal digit (0..9).
    function automatic logic bcd_valid(input logic [BCDW-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = 0; i < NDIGITS; i++) begin
            if (v[i*4 +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Request/result bundle between a requester and the BCD-to-binary converter.
interface bcd_to_bin_seq_if;
    import bcd_pkg::*;

    logic            start;
    logic [BCDW-1:0] bcd_in;
    logic            ready;
    logic            done;
    logic [BINW-1:0] bin_out;
    logic            err;

    modport master (
        output start, bcd_in,
        input  ready, done, bin_out, err
    );

    modport slave (
        input  start, bcd_in,
        output ready, done, bin_out, err
    );

endinterface

// File: rtl/bcd_digit_corr.sv
// Per-digit correction step of reverse double-dabble: subtract 3 from 8..15.
module bcd_digit_corr (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    // Inputs 8..15 map to 5..12, so the 4-bit subtraction never wraps.
    always_comb begin
        digit_o = digit_i[3] ? (digit_i - 4'd3) : digit_i;
    end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential four-digit BCD to 14-bit binary converter (reverse double-dabble).
module bcd_to_bin_seq
    import bcd_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    bcd_to_bin_seq_if.slave bus
);

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [SRW-1:0]  sr_q, sr_d;
    logic [BINW-1:0] bin_q, bin_d;
    logic            err_q, err_d;

    logic [SRW-1:0]  sr_shift;
    logic [BCDW-1:0] corr_digits;
    logic [SRW-1:0]  sr_iter;

    // One iteration: logical shift right of the whole {bcd, bin} register.
    always_comb begin
        sr_shift = sr_q >> 1;
    end

    for (genvar g = 0; g < NDIGITS; g++) begin : g_corr
        bcd_digit_corr u_corr (
            .digit_i (sr_shift[BINW + 4*g +: 4]),
            .digit_o (corr_digits[4*g +: 4])
        );
    end

    // Reassemble corrected digits above the untouched binary field.
    always_comb begin
        sr_iter = {corr_digits, sr_shift[BINW-1:0]};
    end

    // Next-state and datapath selection for IDLE/CONV/DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        bin_d   = bin_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bcd_valid(bus.bcd_in)) begin
                        state_d = CONV;
                        sr_d    = {bus.bcd_in, {BINW{1'b0}}};
                        cnt_d   = '0;
                        err_d   = 1'b0;
                    end else begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        bin_d   = '0;
                    end
                end
            end
            CONV: begin
                sr_d  = sr_iter;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNTW'(ITER - 1)) begin
                    state_d = DONE;
                    bin_d   = sr_iter[BINW-1:0];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state, including held results, with asynchronous abort on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            bin_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
        end
    end

    assign bus.ready   = (state_q == IDLE);
    assign bus.done    = (state_q == DONE);
    assign bus.bin_out = bin_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq using an expected-result queue.
module tb_bcd_to_bin_seq;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    typedef struct {
        logic [15:0] src;
        logic [13:0] bin;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    bcd_to_bin_seq_if bus ();

    bcd_to_bin_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [13:0] dec_val(input logic [15:0] v);
        int s;
        s = int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
        return 14'(s);
    endfunction

    function automatic logic has_bad(input logic [15:0] v);
        return (v[15:12] > 9) || (v[11:8] > 9) || (v[7:4] > 9) || (v[3:0] > 9);
    endfunction

    function automatic exp_t model(input logic [15:0] v);
        exp_t e;
        e.src = v;
        e.err = has_bad(v);
        e.bin = e.err ? 14'd0 : dec_val(v);
        return e;
    endfunction

    // Edges after the present point until done is seen; -1 on timeout.
    task automatic wait_done(output int lat);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (bus.done !== 1'b1) lat = -1;
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (bus.ready !== 1'b1 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.bcd_in = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", bus.ready); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_cmp++; if (bus.bin_out !== 14'd0) begin n_bad++; $display("FAIL reset_bin: got %0d want 0", bus.bin_out); end
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.err); end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_valid();
        logic [15:0] tbl [7];
        exp_t e;
        int lat;
        tbl[0] = 16'h1234;
        tbl[1] = 16'h9999;
        tbl[2] = 16'h0000;
        tbl[3] = 16'h0001;
        tbl[4] = 16'h8090;
        for (int i = 5; i < 7; i++) begin
            tbl[i] = {4'($urandom_range(1, 9)), 4'($urandom_range(0, 9)),
                      4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        end
        for (int i = 0; i < 7; i++) begin
            wait_ready();
            bus.bcd_in = tbl[i];
            bus.start = 1'b1;
            exp_q.push_back(model(tbl[i]));
            @(posedge clk); #1;
            bus.start = 1'b0;
            bus.bcd_in = 16'($urandom);
            n_cmp++; if (bus.ready !== 1'b0) begin n_bad++; $display("FAIL valid_busy[%h]: ready got %b want 0", tbl[i], bus.ready); end
            wait_done(lat);
            n_cmp++; if (lat !== 14) begin n_bad++; $display("FAIL valid_latency[%h]: got %0d want 14", tbl[i], lat); end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++; if (bus.bin_out !== e.bin) begin n_bad++; $display("FAIL valid_bin[%h]: got %0d want %0d", e.src, bus.bin_out, e.bin); end
                n_cmp++; if (bus.err !== e.err) begin n_bad++; $display("FAIL valid_err[%h]: got %b want %b", e.src, bus.err, e.err); end
            end
            @(posedge clk); #1;
            n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL valid_pulse[%h]: done got %b want 0", tbl[i], bus.done); end
        end
    endtask

    task automatic test_invalid();
        exp_t e;
        int lat;
        wait_ready();
        bus.bcd_in = 16'h12A4;
        bus.start = 1'b1;
        exp_q.push_back(model(16'h12A4));
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(lat);
        n_cmp++; if (lat !== 0) begin n_bad++; $display("FAIL invalid_latency: got %0d want 0", lat); end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++; if (bus.err !== e.err) begin n_bad++; $display("FAIL invalid_err: got %b want %b", bus.err, e.err); end
            n_cmp++; if (bus.bin_out !== e.bin) begin n_bad++; $display("FAIL invalid_bin: got %0d want %0d", bus.bin_out, e.bin); end
        end
        @(posedge clk); #1;
        n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL invalid_err_hold: got %b want 1", bus.err); end
        wait_ready();
        bus.bcd_in = 16'h0042;
        bus.start = 1'b1;
        exp_q.push_back(model(16'h0042));
        @(posedge clk); #1;
        bus.start = 1'b0;
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL invalid_err_clear: got %b want 0", bus.err); end
        wait_done(lat);
        n_cmp++; if (lat !== 14) begin n_bad++; $display("FAIL recover_latency: got %0d want 14", lat); end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++; if (bus.bin_out !== e.bin) begin n_bad++; $display("FAIL recover_bin: got %0d want %0d", bus.bin_out, e.bin); end
        end
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (bus.bin_out !== 14'd42) begin n_bad++; $display("FAIL hold_bin: got %0d want 42", bus.bin_out); end
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL hold_err: got %b want 0", bus.err); end
    endtask

    task automatic test_reset_abort();
        exp_t e;
        int lat;
        wait_ready();
        bus.bcd_in = 16'h1234;
        bus.start = 1'b1;
        exp_q.push_back(model(16'h1234));
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        #1;
        n_cmp++; if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready: got %b want 1", bus.ready); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL abort_done: got %b want 0", bus.done); end
        n_cmp++; if (bus.bin_out !== 14'd0) begin n_bad++; $display("FAIL abort_bin: got %0d want 0", bus.bin_out); end
        @(negedge clk);
        reset = 1'b0;
        bus.bcd_in = 16'h0042;
        bus.start = 1'b1;
        exp_q.push_back(model(16'h0042));
        @(posedge clk); #1;
        bus.start = 1'b0;
        n_cmp++; if (bus.ready !== 1'b0) begin n_bad++; $display("FAIL abort_first_accept: ready got %b want 0", bus.ready); end
        wait_done(lat);
        n_cmp++; if (lat !== 14) begin n_bad++; $display("FAIL abort_latency: got %0d want 14", lat); end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++; if (bus.bin_out !== e.bin) begin n_bad++; $display("FAIL abort_bin_after: got %0d want %0d", bus.bin_out, e.bin); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int lat;
        int t1;
        int t2;
        wait_ready();
        bus.bcd_in = 16'h0500;
        bus.start = 1'b1;
        exp_q.push_back(model(16'h0500));
        exp_q.push_back(model(16'h0777));
        @(posedge clk); #1;
        bus.bcd_in = 16'h0777;
        repeat (5) @(posedge clk);
        #1;
        n_cmp++; if (bus.ready !== 1'b0) begin n_bad++; $display("FAIL b2b_busy: ready got %b want 0", bus.ready); end
        wait_done(lat);
        t1 = cyc;
        n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL b2b_latency1: got %0d more edges want 9", lat); end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++; if (bus.bin_out !== e.bin) begin n_bad++; $display("FAIL b2b_bin1: got %0d want %0d", bus.bin_out, e.bin); end
        end
        @(posedge clk); #1;
        n_cmp++; if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL b2b_idle: ready got %b want 1", bus.ready); end
        @(posedge clk); #1;
        bus.start = 1'b0;
        n_cmp++; if (bus.ready !== 1'b0) begin n_bad++; $display("FAIL b2b_accept2: ready got %b want 0", bus.ready); end
        wait_done(lat);
        t2 = cyc;
        n_cmp++; if (lat !== 14) begin n_bad++; $display("FAIL b2b_latency2: got %0d want 14", lat); end
        n_cmp++; if (t2 - t1 !== 16) begin n_bad++; $display("FAIL b2b_spacing: got %0d want 16", t2 - t1); end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++; if (bus.bin_out !== e.bin) begin n_bad++; $display("FAIL b2b_bin2: got %0d want %0d", bus.bin_out, e.bin); end
            n_cmp++; if (bus.err !== e.err) begin n_bad++; $display("FAIL b2b_err2: got %b want %b", bus.err, e.err); end
        end
        @(posedge clk); #1;
        n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL scoreboard_empty: got %0d left want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_valid();
        test_invalid();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
